dht11_sensor_emulator: RTL and testbench
========================================

// Module: dht11_sensor_emulator
// PURPOSE
//  Single-wire responder that behaves as a DHT11 sensor on dht_bus: it detects the host start pulse,
//  answers with the 80us/80us presence sequence, then sends a 40-bit frame {umidade, temperatura, checksum}.
//  Serves as the bus-side model for the dht11 host controller and as an on-board loopback/bring-up source.
// PARAMETERS
//  CLK_FREQ_HZ    50_000_000  clock frequency; US_DIV = CLK_FREQ_HZ/1_000_000 cycles per microsecond
//  START_MIN_US   18000       minimum host low time accepted as a start request
//  RESP_DELAY_US  30          delay from host release to start of presence low
//  PRES_LOW_US    80          presence low time
//  PRES_HIGH_US   80          presence high (released) time
//  BIT_LOW_US     50          low slot before every bit and the trailing end pulse
//  BIT0_HIGH_US   26          released time for a 0 bit
//  BIT1_HIGH_US   70          released time for a 1 bit
// PORTS
//  clock        in     1   system clock
//  reset        in     1   asynchronous reset, active low
//  dht_bus      inout  1   open-drain line: driven 0 or released to 1'bz only, never driven 1
//  enable       in     1   1 = respond to start pulses; 0 = stay released in IDLE
//  umidade      in     16  humidity bytes {int, dec}, sampled at frame latch
//  temperatura  in     16  temperature bytes {int, dec}, sampled at frame latch
//  busy         out    1   1 from frame latch until the end pulse is released
//  frames_sent  out    8   count of completed frames, wraps 255->0
//  db_estado    out    4   current state encoding, debug only
// BEHAVIOUR
//  - dht_bus is sampled through a 2-FF synchronizer (bus_s); all detection uses bus_s.
//  - Reset values: dht_bus=z, busy=0, frames_sent=0, db_estado=IDLE(0), timer and prescaler = 0.
//  - The us-prescaler restarts on every state entry, so each timed state lasts exactly N*US_DIV cycles.
//  - States and transitions:
//    IDLE(0):      released; bus_s falling edge with enable=1 -> HOST_LOW; timer starts.
//    HOST_LOW(1):  released; counts us while bus_s=0 (saturates at START_MIN_US). On bus_s rising edge:
//                  count >= START_MIN_US -> latch frame, busy=1 -> WAIT_RESP; otherwise -> IDLE (glitch ignored).
//    WAIT_RESP(2): released RESP_DELAY_US -> RESP_LOW.
//    RESP_LOW(3):  drive 0 for PRES_LOW_US -> RESP_HIGH.
//    RESP_HIGH(4): released PRES_HIGH_US; bit index = 39 -> BIT_LOW.
//    BIT_LOW(5):   drive 0 for BIT_LOW_US -> BIT_HIGH.
//    BIT_HIGH(6):  released BIT1_HIGH_US if frame[idx]=1, else BIT0_HIGH_US;
//                  idx>0 -> idx-1, BIT_LOW; idx=0 -> END_LOW.
//    END_LOW(7):   drive 0 for BIT_LOW_US, then release; busy=0, frames_sent+1 -> IDLE.
//  - Frame latch: frame = {umidade[15:8], umidade[7:0], temperatura[15:8], temperatura[7:0], chk};
//    chk = 8-bit sum of the four bytes mod 256. Sent MSB first (frame[39] first).
//  - From WAIT_RESP to END_LOW the bus input is ignored (host contention is not detected).
//  - enable falling mid-frame has no effect; the frame completes. enable is checked only in IDLE.
//  - umidade/temperatura changing after the latch do not affect the frame in progress.
//  - Host low longer than START_MIN_US is accepted; the response is timed from the host release.
//  - reset asserted at any point: bus released immediately (async), FSM to IDLE, frame discarded, busy=0.
// CONFIGURATION
//  DHT11_EMU_CHECKSUM_ERR_EN defined: adds input port corrupt_chk (1 bit), sampled at frame latch;
//    when 1, the transmitted checksum is ~chk (fault injection for the host error path).
//  Undefined: no corrupt_chk port; the checksum is always correct.
// TESTING
//  T1 reset low 100ns, enable=1, umidade=16'h1234, temperatura=16'h5ABC; host low 18ms then release
//     -> after 30us: 80us low, 80us high, 40 bits = 40'h12345ABC5C, 50us end low; frames_sent=1, busy=0.
//  T2 umidade=16'h985F, temperatura=16'h76ED, second start -> frame 40'h985F76ED5A (chk 0x5A); frames_sent=2.
//  T3 host low 5ms then release -> no bus activity, busy stays 0, returns to IDLE, frames_sent unchanged.
//  T4 reset asserted during bit 20 -> bus released same cycle, busy=0; next valid start yields a full frame.
//  T5 enable=0, host low 18ms -> no response; change inputs after latch in T1 -> transmitted frame unchanged.
//  T6 (DHT11_EMU_CHECKSUM_ERR_EN) corrupt_chk=1 with T1 data -> last byte 8'hA3; host reports error=1.

Source files
------------

// File: rtl/dht11_sensor_emulator.sv
`timescale 1ns/1ps
// DHT11 bus-side responder: detects a host start pulse, answers with presence, sends a 40-bit frame.
// Latency: response begins RESP_DELAY_US after host release; every timed state lasts exactly N*US_DIV cycles.
// Backpressure: none; an open-drain line. Optional checksum fault injection under DHT11_EMU_CHECKSUM_ERR_EN.
module dht11_sensor_emulator #(
    parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned PRES_LOW_US   = 80,
    parameter int unsigned PRES_HIGH_US  = 80,
    parameter int unsigned BIT_LOW_US    = 50,
    parameter int unsigned BIT0_HIGH_US  = 26,
    parameter int unsigned BIT1_HIGH_US  = 70
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire         dht_bus,
    input  logic        enable,
    input  logic [15:0] umidade,
    input  logic [15:0] temperatura,
`ifdef DHT11_EMU_CHECKSUM_ERR_EN
    input  logic        corrupt_chk,
`endif
    output logic        busy,
    output logic [7:0]  frames_sent,
    output logic [3:0]  db_estado
);

    localparam int unsigned US_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(US_DIV - 1);

    localparam logic [15:0] T_START = 16'(START_MIN_US);
    localparam logic [15:0] T_RESP  = 16'(RESP_DELAY_US);
    localparam logic [15:0] T_PLOW  = 16'(PRES_LOW_US);
    localparam logic [15:0] T_PHIGH = 16'(PRES_HIGH_US);
    localparam logic [15:0] T_BLOW  = 16'(BIT_LOW_US);
    localparam logic [15:0] T_B0    = 16'(BIT0_HIGH_US);
    localparam logic [15:0] T_B1    = 16'(BIT1_HIGH_US);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HOST_LOW  = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_RESP_LOW  = 3'd3;
    localparam logic [2:0] S_RESP_HIGH = 3'd4;
    localparam logic [2:0] S_BIT_LOW   = 3'd5;
    localparam logic [2:0] S_BIT_HIGH  = 3'd6;
    localparam logic [2:0] S_END_LOW   = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   timer_q, timer_d;
    logic [5:0]    bit_idx_q, bit_idx_d;
    logic [39:0]   frame_q, frame_d;
    logic          busy_q, busy_d;
    logic [7:0]    frames_q, frames_d;
    logic          drive_low_q, drive_low_d;
    logic          bus_meta_q, bus_s_q, bus_prev_q;

    logic [7:0]  chk_sum;
    logic [7:0]  chk_tx;
    logic [15:0] dur;
    logic        tick;
    logic        done;
    logic        bus_rise;
    logic        bus_fall;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_meta_q <= 1'b1;
            bus_s_q    <= 1'b1;
            bus_prev_q <= 1'b1;
        end else begin
            bus_meta_q <= dht_bus;
            bus_s_q    <= bus_meta_q;
            bus_prev_q <= bus_s_q;
        end
    end

    assign bus_rise = bus_s_q & ~bus_prev_q;
    assign bus_fall = ~bus_s_q & bus_prev_q;

    always_comb begin
        chk_sum = umidade[15:8] + umidade[7:0] + temperatura[15:8] + temperatura[7:0];
`ifdef DHT11_EMU_CHECKSUM_ERR_EN
        chk_tx = corrupt_chk ? ~chk_sum : chk_sum;
`else
        chk_tx = chk_sum;
`endif
    end

    always_comb begin
        dur = 16'd0;
        case (state_q)
            S_WAIT_RESP: dur = T_RESP;
            S_RESP_LOW:  dur = T_PLOW;
            S_RESP_HIGH: dur = T_PHIGH;
            S_BIT_LOW:   dur = T_BLOW;
            S_END_LOW:   dur = T_BLOW;
            S_BIT_HIGH:  dur = frame_q[bit_idx_q] ? T_B1 : T_B0;
            default:     dur = 16'd0;
        endcase
    end

    assign tick = (pre_q == PRE_LAST);
    assign done = tick && (timer_q == dur - 16'd1);

    always_comb begin
        state_d   = state_q;
        pre_d     = tick ? '0 : pre_q + 1'b1;
        timer_d   = tick ? timer_q + 16'd1 : timer_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        busy_d    = busy_q;
        frames_d  = frames_q;

        case (state_q)
            S_IDLE: begin
                pre_d   = '0;
                timer_d = '0;
                if (enable && bus_fall) state_d = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                // Only low time counts, saturating so a long host pulse cannot wrap.
                timer_d = (tick && !bus_s_q && timer_q < T_START) ? timer_q + 16'd1 : timer_q;
                if (bus_rise) begin
                    if (timer_q >= T_START) begin
                        frame_d = {umidade, temperatura, chk_tx};
                        busy_d  = 1'b1;
                        state_d = S_WAIT_RESP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_RESP: if (done) state_d = S_RESP_LOW;
            S_RESP_LOW:  if (done) state_d = S_RESP_HIGH;
            S_RESP_HIGH: begin
                if (done) begin
                    bit_idx_d = 6'd39;
                    state_d   = S_BIT_LOW;
                end
            end
            S_BIT_LOW:   if (done) state_d = S_BIT_HIGH;
            S_BIT_HIGH: begin
                if (done) begin
                    if (bit_idx_q == 6'd0) begin
                        state_d = S_END_LOW;
                    end else begin
                        bit_idx_d = bit_idx_q - 6'd1;
                        state_d   = S_BIT_LOW;
                    end
                end
            end
            S_END_LOW: begin
                if (done) begin
                    busy_d   = 1'b0;
                    frames_d = frames_q + 8'd1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            pre_d   = '0;
            timer_d = '0;
        end

        drive_low_d = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) || (state_d == S_END_LOW);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            frame_q     <= '0;
            busy_q      <= 1'b0;
            frames_q    <= '0;
            drive_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            frame_q     <= frame_d;
            busy_q      <= busy_d;
            frames_q    <= frames_d;
            drive_low_q <= drive_low_d;
        end
    end

    assign dht_bus     = drive_low_q ? 1'b0 : 1'bz;
    assign busy        = busy_q;
    assign frames_sent = frames_q;
    assign db_estado   = {1'b0, state_q};

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
`timescale 1ns/1ps
// Directed bench for dht11_sensor_emulator: acts as the host, decodes pulse widths into frames.
module tb_dht11_sensor_emulator;

    localparam int unsigned CLK_HZ   = 2_000_000;
    localparam int          US       = 2;
    localparam int          START_US = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable;
    logic        host_low;
    logic [15:0] umidade;
    logic [15:0] temperatura;
    logic        busy;
    logic [7:0]  frames_sent;
    logic [3:0]  db_estado;
    wire         dht_bus;
`ifdef DHT11_EMU_CHECKSUM_ERR_EN
    logic        corrupt_chk;
`endif

    assign dht_bus = host_low ? 1'b0 : 1'bz;
    pullup (dht_bus);

    always #250 clock = ~clock;

    dht11_sensor_emulator #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .START_MIN_US (START_US)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .dht_bus     (dht_bus),
        .enable      (enable),
        .umidade     (umidade),
        .temperatura (temperatura),
`ifdef DHT11_EMU_CHECKSUM_ERR_EN
        .corrupt_chk (corrupt_chk),
`endif
        .busy        (busy),
        .frames_sent (frames_sent),
        .db_estado   (db_estado)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] u;
        logic [15:0] t;
        logic [39:0] frame;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic bus_low();
        return dht_bus === 1'b0;
    endfunction

    // Counts consecutive negedge samples at the given level, current sample included.
    task automatic measure(input logic lvl, input int max, output int n);
        n = 0;
        while ((bus_low() == !lvl) && n < max) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic run_frame(input logic [15:0] u, input logic [15:0] t,
                             input logic [39:0] exp_frame, input logic [7:0] exp_cnt,
                             input string tag);
        int n;
        int bad_low;
        int bad_high;
        logic [39:0] got;
        umidade     = u;
        temperatura = t;
        host_low    = 1'b1;
        repeat ((START_US + 2) * US) @(negedge clock);
        host_low = 1'b0;
        @(negedge clock);
        measure(1'b1, 1000, n);
        check_rng({tag, " resp_delay"}, n, 58, 66);
        check({tag, " busy_mid"}, 40'(busy), 40'd1);
        // Frame is already latched; these must not leak into it.
        umidade     = ~u;
        temperatura = ~t;
        measure(1'b0, 1000, n);
        check({tag, " pres_low"}, 40'(n), 40'd160);
        measure(1'b1, 1000, n);
        check({tag, " pres_high"}, 40'(n), 40'd160);
        bad_low  = 0;
        bad_high = 0;
        got      = '0;
        for (int i = 39; i >= 0; i--) begin
            measure(1'b0, 1000, n);
            if (n != 100) bad_low++;
            measure(1'b1, 1000, n);
            if (n == 140) got[i] = 1'b1;
            else if (n != 52) bad_high++;
        end
        check({tag, " bit_low_errs"}, 40'(bad_low), 40'd0);
        check({tag, " bit_high_errs"}, 40'(bad_high), 40'd0);
        check({tag, " frame"}, got, exp_frame);
        measure(1'b0, 1000, n);
        check({tag, " end_low"}, 40'(n), 40'd100);
        repeat (2) @(negedge clock);
        check({tag, " busy_end"}, 40'(busy), 40'd0);
        check({tag, " frames_sent"}, 40'(frames_sent), 40'(exp_cnt));
        check({tag, " state_end"}, 40'(db_estado), 40'd0);
        check({tag, " bus_released"}, 40'(bus_low()), 40'd0);
    endtask

    task automatic watch_idle(input string tag, input logic [7:0] exp_cnt);
        int lows;
        int busy_seen;
        lows      = 0;
        busy_seen = 0;
        repeat (400) begin
            @(negedge clock);
            if (bus_low()) lows++;
            if (busy === 1'b1) busy_seen++;
        end
        check({tag, " bus_lows"}, 40'(lows), 40'd0);
        check({tag, " busy_seen"}, 40'(busy_seen), 40'd0);
        check({tag, " state"}, 40'(db_estado), 40'd0);
        check({tag, " frames_sent"}, 40'(frames_sent), 40'(exp_cnt));
    endtask

    initial begin
        #(90000 * 500);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        logic prev;

        vecs[0] = '{16'h1234, 16'h5ABC, 40'h12345ABC5C};
        vecs[1] = '{16'h985F, 16'h76ED, 40'h985F76ED5A};
        vecs[2] = '{16'h0000, 16'h0000, 40'h0000000000};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 40'hFFFFFFFFFC};

        enable      = 1'b1;
        host_low    = 1'b0;
        umidade     = 16'h0;
        temperatura = 16'h0;
`ifdef DHT11_EMU_CHECKSUM_ERR_EN
        corrupt_chk = 1'b0;
`endif
        #100;
        check("rst busy", 40'(busy), 40'd0);
        check("rst frames_sent", 40'(frames_sent), 40'd0);
        check("rst state", 40'(db_estado), 40'd0);
        check("rst bus", 40'(bus_low()), 40'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 4; i++)
            run_frame(vecs[i].u, vecs[i].t, vecs[i].frame, 8'(i + 1), $sformatf("vec%0d", i));

        // Short host pulse is a glitch and must be ignored.
        host_low = 1'b1;
        repeat (10 * US) @(negedge clock);
        check("short host_low_state", 40'(db_estado), 40'd1);
        repeat (10 * US) @(negedge clock);
        host_low = 1'b0;
        watch_idle("short", 8'd4);

        enable   = 1'b0;
        host_low = 1'b1;
        repeat ((START_US + 2) * US) @(negedge clock);
        check("disabled host_low_state", 40'(db_estado), 40'd0);
        host_low = 1'b0;
        watch_idle("disabled", 8'd4);
        enable = 1'b1;

        // Abort mid-frame during the low slot of bit 20 (21st low pulse).
        umidade     = vecs[0].u;
        temperatura = vecs[0].t;
        host_low    = 1'b1;
        repeat ((START_US + 2) * US) @(negedge clock);
        host_low = 1'b0;
        lows = 0;
        prev = 1'b0;
        for (int c = 0; c < 12000 && lows < 21; c++) begin
            @(negedge clock);
            if (bus_low() && !prev) lows++;
            prev = bus_low();
        end
        check("abort reach_bit20", 40'(lows), 40'd21);
        repeat (10) @(negedge clock);
        check("abort state_bit_low", 40'(db_estado), 40'd5);
        reset = 1'b0;
        #1;
        check("abort bus", 40'(bus_low()), 40'd0);
        check("abort busy", 40'(busy), 40'd0);
        check("abort state", 40'(db_estado), 40'd0);
        check("abort frames_sent", 40'(frames_sent), 40'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        run_frame(vecs[0].u, vecs[0].t, vecs[0].frame, 8'd1, "after_abort");

`ifdef DHT11_EMU_CHECKSUM_ERR_EN
        corrupt_chk = 1'b1;
        run_frame(16'h1234, 16'h5ABC, 40'h12345ABCA3, 8'd2, "corrupt_chk");
        corrupt_chk = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
